// File: rtl/key_scan_control.sv
// key_scan_control: conditions the raw active-low board pushbuttons into
// debounced levels and one-cycle press pulses. The pulses from KEY[0..2]
// drive the LED scanner's run/pause flag and its saturating speed select.
// Everything runs in the CLOCK_50 domain; KEY is asynchronous to it.
module key_scan_control #(
    parameter int NUM_KEYS        = 3,        // must be >= 3: KEY[0..2] are decoded
    parameter int DEBOUNCE_CYCLES = 1000000,  // 20 ms at 50 MHz
    parameter int CNT_W           = 20,       // 2**CNT_W > DEBOUNCE_CYCLES
    parameter int SPEED_W         = 3,
    parameter int SPEED_MAX       = 7,
    parameter int SPEED_RESET     = 3
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                run,
    output logic [SPEED_W-1:0]  speed
);

    typedef enum logic {
        ST_STABLE,
        ST_CONFIRM
    } db_state_e;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SPEED_W-1:0] SPEED_TOP  = SPEED_W'(SPEED_MAX);
    localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(SPEED_RESET);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] sync;
    db_state_e           state_q [NUM_KEYS];
    db_state_e           state_d [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] level_dly_q;
    logic [NUM_KEYS-1:0] press_q;
    logic                run_q, run_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;

    // Two-flop synchronizer on the raw pins; reset to 1 so a released key is seen.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            // NOTE: non-blocking so sync2_q takes the old sync1_q, giving two real flop stages.
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    // Active-high synchronized key state; everything downstream uses only this.
    assign sync = ~sync2_q;

    // Per-key debounce: accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            // NOTE: every output gets its hold value first, so no path leaves it unassigned (no latch).
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                ST_STABLE: begin
                    if (sync[i] != level_q[i]) begin
                        state_d[i] = ST_CONFIRM;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if (sync[i] == level_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        level_d[i] = ~level_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Debounce state, counters and levels; a reset discards any partial count.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: these per-key arrays are control state, not storage, so every entry is reset.
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q <= level_d;
        end
    end

    // Registered rising-edge detect on the debounced level: one pulse per press, none on release.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            level_dly_q <= '0;
            press_q     <= '0;
        end else begin
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    // Control decode: KEY0 toggles run, KEY1/KEY2 step speed with explicit saturation checks.
    always_comb begin
        run_d   = run_q;
        speed_d = speed_q;
        if (press_q[0]) begin
            run_d = ~run_q;
        end
        // Opposing speed keys in the same cycle cancel out.
        if (press_q[1] && !press_q[2] && (speed_q < SPEED_TOP)) begin
            speed_d = speed_q + SPEED_W'(1);
        end else if (press_q[2] && !press_q[1] && (speed_q != '0)) begin
            speed_d = speed_q - SPEED_W'(1);
        end
    end

    // Control registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            run_q   <= 1'b1;
            speed_q <= SPEED_INIT;
        end else begin
            run_q   <= run_d;
            speed_q <= speed_d;
        end
    end

    assign key_level = level_q;
    assign key_press = press_q;
    assign run       = run_q;
    assign speed     = speed_q;

endmodule
